// File: rtl/robo_coletor_param.sv
// robo_coletor_param: left-hand wall-follower collector robot with pose, move and item tracking.
// Optional `ROBO_BARRIER_REMOVE_EN: clear removable barriers instead of treating them as walls.
module robo_coletor_param #(
  parameter int         ROWS      = 9,
  parameter int         COLS      = 10,
  parameter int         START_ROW = 4,
  parameter int         START_COL = 3,
  parameter logic [1:0] START_DIR = 2'b00,
  parameter int         MAX_MOVES = 200,
  parameter int         CNT_W     = 8,
  localparam int        RW        = $clog2(ROWS + 1),
  localparam int        CW        = $clog2(COLS + 1),
  localparam int        MW        = $clog2(MAX_MOVES + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             head,
  input  logic             left,
  input  logic             under,
  input  logic             barrier,
  output logic             advance,
  output logic             turn,
  output logic             collect,
  output logic             remove,
  output logic [RW-1:0]    row,
  output logic [CW-1:0]    col,
  output logic [1:0]       dir,
  output logic [MW-1:0]    moves,
  output logic [CNT_W-1:0] collected,
  output logic             done,
  output logic             stuck
);

  localparam logic [1:0] DIR_N = 2'b00;
  localparam logic [1:0] DIR_S = 2'b01;
  localparam logic [1:0] DIR_L = 2'b10;
  localparam logic [1:0] DIR_O = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t state, state_next;

  logic             turned_left, turned_left_next;
  logic [2:0]       turn_run, turn_run_next;
  logic             advance_next, turn_next, collect_next, remove_next;
  logic [RW-1:0]    row_next;
  logic [CW-1:0]    col_next;
  logic [1:0]       dir_next;
  logic [MW-1:0]    moves_next;
  logic [CNT_W-1:0] collected_next;
  logic             done_next, stuck_next;

  logic at_edge;
  logic head_eff;
  logic remove_ok;

  // Counter-clockwise quarter turn: N -> O -> S -> L -> N.
  function automatic logic [1:0] rotate_left(input logic [1:0] d);
    case (d)
      DIR_N:   rotate_left = DIR_O;
      DIR_O:   rotate_left = DIR_S;
      DIR_S:   rotate_left = DIR_L;
      default: rotate_left = DIR_N;
    endcase
  endfunction

  // The grid border is a wall: stepping forward would leave rows 1..ROWS / cols 1..COLS.
  always_comb begin
    at_edge = 1'b0;
    case (dir)
      DIR_N:   at_edge = (row == RW'(1));
      DIR_S:   at_edge = (row == RW'(ROWS));
      DIR_L:   at_edge = (col == CW'(COLS));
      default: at_edge = (col == CW'(1));
    endcase
  end

`ifdef ROBO_BARRIER_REMOVE_EN
  assign head_eff  = head | at_edge;
  assign remove_ok = barrier & ~at_edge;
`else
  assign head_eff  = head | barrier | at_edge;
  assign remove_ok = 1'b0;
`endif

  always_comb begin
    state_next       = state;
    advance_next     = 1'b0;
    turn_next        = 1'b0;
    collect_next     = 1'b0;
    remove_next      = 1'b0;
    row_next         = row;
    col_next         = col;
    dir_next         = dir;
    moves_next       = moves;
    collected_next   = collected;
    turned_left_next = turned_left;
    turn_run_next    = turn_run;
    done_next        = done;
    stuck_next       = stuck;

    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_RUN;
      end

      ST_RUN: begin
        moves_next    = moves + 1'b1;
        turn_run_next = 3'd0;

        if (under) begin
          collect_next = 1'b1;
          if (collected != '1) collected_next = collected + 1'b1;
        end else if (remove_ok) begin
          remove_next = 1'b1;
        end else if (!left && !turned_left) begin
          turn_next = 1'b1;
        end else if (!head_eff) begin
          advance_next     = 1'b1;
          turned_left_next = 1'b0;
          case (dir)
            DIR_N:   row_next = row - 1'b1;
            DIR_S:   row_next = row + 1'b1;
            DIR_L:   col_next = col + 1'b1;
            default: col_next = col - 1'b1;
          endcase
        end else begin
          turn_next = 1'b1;
        end

        if (turn_next) begin
          dir_next         = rotate_left(dir);
          turned_left_next = 1'b1;
          turn_run_next    = turn_run + 3'd1;
        end

        // A full spin without any other action means the robot is boxed in.
        if (turn_run_next == 3'd4) stuck_next = 1'b1;

        if (stuck_next || (moves_next == MW'(MAX_MOVES))) begin
          done_next  = 1'b1;
          state_next = ST_DONE;
        end
      end

      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      advance     <= 1'b0;
      turn        <= 1'b0;
      collect     <= 1'b0;
      remove      <= 1'b0;
      row         <= RW'(START_ROW);
      col         <= CW'(START_COL);
      dir         <= START_DIR;
      moves       <= '0;
      collected   <= '0;
      done        <= 1'b0;
      stuck       <= 1'b0;
      turned_left <= 1'b0;
      turn_run    <= 3'd0;
    end else begin
      state       <= state_next;
      advance     <= advance_next;
      turn        <= turn_next;
      collect     <= collect_next;
      remove      <= remove_next;
      row         <= row_next;
      col         <= col_next;
      dir         <= dir_next;
      moves       <= moves_next;
      collected   <= collected_next;
      done        <= done_next;
      stuck       <= stuck_next;
      turned_left <= turned_left_next;
      turn_run    <= turn_run_next;
    end
  end

endmodule

// File: tb/tb_robo_coletor_param.sv
// Scoreboard bench for robo_coletor_param: default, large-budget and small-budget instances share stimulus.
module tb_robo_coletor_param;

  typedef logic [47:0] vec_t;

  localparam logic [3:0] A_NONE = 4'b0000;
  localparam logic [3:0] A_ADV  = 4'b1000;
  localparam logic [3:0] A_TURN = 4'b0100;
  localparam logic [3:0] A_COLL = 4'b0010;
  localparam logic [3:0] A_REM  = 4'b0001;
  localparam logic [1:0] H_N = 2'b00;
  localparam logic [1:0] H_S = 2'b01;
  localparam logic [1:0] H_L = 2'b10;
  localparam logic [1:0] H_O = 2'b11;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic head = 1'b0;
  logic left = 1'b0;
  logic under = 1'b0;
  logic barrier = 1'b0;

  logic d_advance, d_turn, d_collect, d_remove, d_done, d_stuck;
  logic [3:0] d_row, d_col;
  logic [1:0] d_dir;
  logic [7:0] d_moves, d_collected;

  logic s_advance, s_turn, s_collect, s_remove, s_done, s_stuck;
  logic [3:0] s_row, s_col;
  logic [1:0] s_dir;
  logic [8:0] s_moves;
  logic [7:0] s_collected;

  logic m_advance, m_turn, m_collect, m_remove, m_done, m_stuck;
  logic [3:0] m_row, m_col;
  logic [1:0] m_dir;
  logic [2:0] m_moves;
  logic [7:0] m_collected;

  int checks = 0;
  int passed = 0;
  vec_t sb[$];

  always #5 clock = ~clock;

  robo_coletor_param u_dut (
    .clock(clock), .reset(reset), .start(start), .head(head), .left(left),
    .under(under), .barrier(barrier),
    .advance(d_advance), .turn(d_turn), .collect(d_collect), .remove(d_remove),
    .row(d_row), .col(d_col), .dir(d_dir), .moves(d_moves),
    .collected(d_collected), .done(d_done), .stuck(d_stuck)
  );

  robo_coletor_param #(.MAX_MOVES(300)) u_sat (
    .clock(clock), .reset(reset), .start(start), .head(head), .left(left),
    .under(under), .barrier(barrier),
    .advance(s_advance), .turn(s_turn), .collect(s_collect), .remove(s_remove),
    .row(s_row), .col(s_col), .dir(s_dir), .moves(s_moves),
    .collected(s_collected), .done(s_done), .stuck(s_stuck)
  );

  robo_coletor_param #(.MAX_MOVES(5)) u_small (
    .clock(clock), .reset(reset), .start(start), .head(head), .left(left),
    .under(under), .barrier(barrier),
    .advance(m_advance), .turn(m_turn), .collect(m_collect), .remove(m_remove),
    .row(m_row), .col(m_col), .dir(m_dir), .moves(m_moves),
    .collected(m_collected), .done(m_done), .stuck(m_stuck)
  );

  // Field layout: act{adv,turn,coll,rem} | row | col | dir | moves | collected | done | stuck
  function automatic vec_t mk(input logic [3:0] act, input int r, input int c,
                              input logic [1:0] d, input int mv, input int coll,
                              input logic dn, input logic st);
    return {act, 8'(r), 8'(c), d, 16'(mv), 8'(coll), dn, st};
  endfunction

  function automatic vec_t obs_d();
    return {d_advance, d_turn, d_collect, d_remove, 8'(d_row), 8'(d_col), d_dir,
            16'(d_moves), d_collected, d_done, d_stuck};
  endfunction

  function automatic vec_t obs_s();
    return {s_advance, s_turn, s_collect, s_remove, 8'(s_row), 8'(s_col), s_dir,
            16'(s_moves), s_collected, s_done, s_stuck};
  endfunction

  function automatic vec_t obs_m();
    return {m_advance, m_turn, m_collect, m_remove, 8'(m_row), 8'(m_col), m_dir,
            16'(m_moves), m_collected, m_done, m_stuck};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    start = 1'b0; head = 1'b0; left = 1'b0; under = 1'b0; barrier = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    vec_t got, want;
    apply_reset();
    for (int i = 0; i < 5; i++) sb.push_back(mk(A_NONE, 4, 3, H_N, 0, 0, 1'b0, 1'b0));
    for (int i = 0; i < 5; i++) begin
      step();
      got = obs_d(); want = sb.pop_front(); checks++;
      if (got !== want) $display("FAIL reset_idle[%0d]: got %h expected %h", i, got, want);
      else passed++;
    end
    start = 1'b1; head = 1'b0; left = 1'b1;
    sb.push_back(mk(A_ADV, 3, 3, H_N, 1, 0, 1'b0, 1'b0));
    sb.push_back(mk(A_NONE, 4, 3, H_N, 0, 0, 1'b0, 1'b0));
    step();
    step();
    got = obs_d(); want = sb.pop_front(); checks++;
    if (got !== want) $display("FAIL midrun_advance: got %h expected %h", got, want);
    else passed++;
    #2 reset = 1'b1;
    #1;
    got = obs_d(); want = sb.pop_front(); checks++;
    if (got !== want) $display("FAIL async_reset: got %h expected %h", got, want);
    else passed++;
    @(posedge clock);
    #1 reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_advance();
    vec_t got, want;
    apply_reset();
    start = 1'b1; head = 1'b0; left = 1'b1;
    sb.push_back(mk(A_NONE, 4, 3, H_N, 0, 0, 1'b0, 1'b0));
    sb.push_back(mk(A_ADV,  3, 3, H_N, 1, 0, 1'b0, 1'b0));
    sb.push_back(mk(A_ADV,  2, 3, H_N, 2, 0, 1'b0, 1'b0));
    sb.push_back(mk(A_ADV,  1, 3, H_N, 3, 0, 1'b0, 1'b0));
    sb.push_back(mk(A_TURN, 1, 3, H_O, 4, 0, 1'b0, 1'b0));
    for (int i = 0; i < 5; i++) begin
      step();
      got = obs_d(); want = sb.pop_front(); checks++;
      if (got !== want) $display("FAIL advance[%0d]: got %h expected %h", i, got, want);
      else passed++;
    end
    $display("test_advance done");
  endtask

  task automatic test_collect();
    vec_t got, want;
    apply_reset();
    start = 1'b1; under = 1'b1; head = 1'b0; left = 1'b1;
    sb.push_back(mk(A_NONE, 4, 3, H_N, 0, 0, 1'b0, 1'b0));
    for (int k = 1; k <= 300; k++)
      sb.push_back(mk(A_COLL, 4, 3, H_N, k, (k > 255) ? 255 : k, (k == 300), 1'b0));
    for (int i = 0; i <= 300; i++) begin
      step();
      got = obs_s(); want = sb.pop_front(); checks++;
      if (got !== want) $display("FAIL collect_sat[%0d]: got %h expected %h", i, got, want);
      else passed++;
    end
    want = mk(A_NONE, 4, 3, H_N, 200, 200, 1'b1, 1'b0);
    got = obs_d(); checks++;
    if (got !== want) $display("FAIL collect_budget_default: got %h expected %h", got, want);
    else passed++;
    $display("test_collect done");
  endtask

  task automatic test_left_turn();
    vec_t got, want;
    apply_reset();
    start = 1'b1; left = 1'b0; head = 1'b0;
    sb.push_back(mk(A_NONE, 4, 3, H_N, 0, 0, 1'b0, 1'b0));
    sb.push_back(mk(A_TURN, 4, 3, H_O, 1, 0, 1'b0, 1'b0));
    sb.push_back(mk(A_ADV,  4, 2, H_O, 2, 0, 1'b0, 1'b0));
    sb.push_back(mk(A_TURN, 4, 2, H_S, 3, 0, 1'b0, 1'b0));
    for (int i = 0; i < 4; i++) begin
      step();
      got = obs_d(); want = sb.pop_front(); checks++;
      if (got !== want) $display("FAIL left_turn[%0d]: got %h expected %h", i, got, want);
      else passed++;
    end
    $display("test_left_turn done");
  endtask

  task automatic test_stuck();
    vec_t got, want;
    apply_reset();
    start = 1'b1; head = 1'b1; left = 1'b1;
    sb.push_back(mk(A_NONE, 4, 3, H_N, 0, 0, 1'b0, 1'b0));
    sb.push_back(mk(A_TURN, 4, 3, H_O, 1, 0, 1'b0, 1'b0));
    sb.push_back(mk(A_TURN, 4, 3, H_S, 2, 0, 1'b0, 1'b0));
    sb.push_back(mk(A_TURN, 4, 3, H_L, 3, 0, 1'b0, 1'b0));
    sb.push_back(mk(A_TURN, 4, 3, H_N, 4, 0, 1'b1, 1'b1));
    for (int i = 0; i < 4; i++) sb.push_back(mk(A_NONE, 4, 3, H_N, 4, 0, 1'b1, 1'b1));
    for (int i = 0; i < 9; i++) begin
      if (i >= 5) start = ~start;
      step();
      got = obs_d(); want = sb.pop_front(); checks++;
      if (got !== want) $display("FAIL stuck[%0d]: got %h expected %h", i, got, want);
      else passed++;
    end
    $display("test_stuck done");
  endtask

  task automatic test_budget();
    vec_t got, want;
    apply_reset();
    start = 1'b1; head = 1'b0; left = 1'b1;
    sb.push_back(mk(A_NONE, 4, 3, H_N, 0, 0, 1'b0, 1'b0));
    sb.push_back(mk(A_ADV,  3, 3, H_N, 1, 0, 1'b0, 1'b0));
    sb.push_back(mk(A_ADV,  2, 3, H_N, 2, 0, 1'b0, 1'b0));
    sb.push_back(mk(A_ADV,  1, 3, H_N, 3, 0, 1'b0, 1'b0));
    sb.push_back(mk(A_TURN, 1, 3, H_O, 4, 0, 1'b0, 1'b0));
    sb.push_back(mk(A_ADV,  1, 2, H_O, 5, 0, 1'b1, 1'b0));
    sb.push_back(mk(A_NONE, 1, 2, H_O, 5, 0, 1'b1, 1'b0));
    sb.push_back(mk(A_NONE, 1, 2, H_O, 5, 0, 1'b1, 1'b0));
    for (int i = 0; i < 8; i++) begin
      step();
      got = obs_m(); want = sb.pop_front(); checks++;
      if (got !== want) $display("FAIL budget[%0d]: got %h expected %h", i, got, want);
      else passed++;
    end
    $display("test_budget done");
  endtask

  task automatic test_barrier();
    vec_t got, want;
    apply_reset();
    start = 1'b1; head = 1'b0; left = 1'b1; barrier = 1'b1;
    sb.push_back(mk(A_NONE, 4, 3, H_N, 0, 0, 1'b0, 1'b0));
`ifdef ROBO_BARRIER_REMOVE_EN
    sb.push_back(mk(A_REM,  4, 3, H_N, 1, 0, 1'b0, 1'b0));
    sb.push_back(mk(A_REM,  4, 3, H_N, 2, 0, 1'b0, 1'b0));
    sb.push_back(mk(A_COLL, 4, 3, H_N, 3, 1, 1'b0, 1'b0));
`else
    sb.push_back(mk(A_TURN, 4, 3, H_O, 1, 0, 1'b0, 1'b0));
    sb.push_back(mk(A_TURN, 4, 3, H_S, 2, 0, 1'b0, 1'b0));
    sb.push_back(mk(A_COLL, 4, 3, H_S, 3, 1, 1'b0, 1'b0));
`endif
    for (int i = 0; i < 4; i++) begin
      if (i == 3) under = 1'b1;
      step();
      got = obs_d(); want = sb.pop_front(); checks++;
      if (got !== want) $display("FAIL barrier[%0d]: got %h expected %h", i, got, want);
      else passed++;
    end
    $display("test_barrier done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", passed, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_advance();
    test_collect();
    test_left_turn();
    test_stuck();
    test_budget();
    test_barrier();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
